// File: rtl/sequenciador_movimentos.sv
// sequenciador_movimentos: FIFO of 3-bit move codes dispatched one at a time to the servo manager
//   clock/reset      : rising-edge clock, asynchronous active-high reset
//   push/move_in     : enqueue a move (dropped when cheio or cancela)
//   iniciar/cancela  : start dispatch (sampled in OCIOSO) / synchronous flush and abort
//   pronto_movimento : completion pulse from the servo manager (honoured in AGUARDA only)
//   move/executa     : held move code and one-cycle start strobe
//   vazio/cheio/contagem/ocupado/fim_sequencia/db_estado : status
//   Optional feature: define SEQ_SETTLE_EN to add SETTLE cycles of settle after each move
module sequenciador_movimentos #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int SETTLE = 5000000,
  parameter int SW     = 23
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [2:0]    move_in,
  input  logic          iniciar,
  input  logic          cancela,
  input  logic          pronto_movimento,
  output logic [2:0]    move,
  output logic          executa,
  output logic          vazio,
  output logic          cheio,
  output logic          ocupado,
  output logic          fim_sequencia,
  output logic [AW:0]   contagem,
  output logic [2:0]    db_estado
);
  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    EXECUTA = 3'd2,
    AGUARDA = 3'd3,
    ASSENTA = 3'd4,
    FIM     = 3'd5
  } estado_t;
  estado_t state, nxt, fin;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop, done;
  if ((64'd1 << SW) <= 64'(SETTLE)) begin : g_sw_check
    $error("SW too narrow for SETTLE");
  end
`ifdef SEQ_SETTLE_EN
  localparam bit SETTLE_EN = 1'b1;
  logic [SW-1:0] cnt;
  assign done = cnt == SW'(SETTLE - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (cancela || state != ASSENTA || done) ? '0 : cnt + 1'b1;
`else
  localparam bit SETTLE_EN = 1'b0;
  assign done = 1'b0;
`endif
  assign vazio         = contagem == '0;
  assign cheio         = contagem == (AW+1)'(DEPTH);
  assign push_ok       = push && !cheio && !cancela;
  assign pop           = state == CARREGA && !vazio && !cancela;
  assign executa       = state == EXECUTA;
  assign fim_sequencia = state == FIM;
  assign ocupado       = state != OCIOSO;
  assign db_estado     = state;
  assign fin           = vazio ? FIM : CARREGA;
  always_comb begin
    nxt = state;
    case (state)
      OCIOSO:  nxt = iniciar ? fin : OCIOSO;
      CARREGA: nxt = EXECUTA;
      EXECUTA: nxt = AGUARDA;
      AGUARDA: nxt = !pronto_movimento ? AGUARDA : SETTLE_EN ? ASSENTA : fin;
      ASSENTA: nxt = done ? fin : ASSENTA;
      FIM:     nxt = OCIOSO;
      default: nxt = OCIOSO;
    endcase
    if (cancela) nxt = OCIOSO;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= OCIOSO;
    else state <= nxt;
  always_ff @(posedge clock)
    if (push_ok) mem[wr_ptr] <= move_in;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      contagem <= '0;
      move     <= '0;
    end else if (cancela) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      contagem <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) move <= mem[rd_ptr];
      contagem <= (push_ok && !pop) ? contagem + 1'b1 : (pop && !push_ok) ? contagem - 1'b1 : contagem;
    end
endmodule

// File: tb/tb_sequenciador_movimentos.sv
// tb_sequenciador_movimentos: scoreboard bench for the move sequencer
module tb_sequenciador_movimentos;
  localparam int DEPTH = 16, AW = 4, SETTLE = 10, SW = 4;
`ifdef SEQ_SETTLE_EN
  localparam int LAT = SETTLE + 2;
`else
  localparam int LAT = 2;
`endif
  logic clock = 0, reset = 0, push = 0, iniciar = 0, cancela = 0, pronto_movimento = 0;
  logic [2:0] move_in = 0, move, db_estado;
  logic executa, vazio, cheio, ocupado, fim_sequencia;
  logic [AW:0] contagem;
  int tests = 0, fails = 0, n_exec = 0, n_fim = 0;
  logic [2:0] exp_q[$];
  sequenciador_movimentos #(.DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE), .SW(SW)) dut (
    .clock(clock), .reset(reset), .push(push), .move_in(move_in), .iniciar(iniciar),
    .cancela(cancela), .pronto_movimento(pronto_movimento), .move(move), .executa(executa),
    .vazio(vazio), .cheio(cheio), .ocupado(ocupado), .fim_sequencia(fim_sequencia),
    .contagem(contagem), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (!reset && fim_sequencia) n_fim++;
    if (!reset && executa) begin
      logic [2:0] e;
      n_exec++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL exec_unexpected move=%0d required=none", move);
      end else begin
        e = exp_q.pop_front();
        if (move !== e) begin
          fails++;
          $display("FAIL exec_order move=%0d required=%0d", move, e);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic push_mv(input logic [2:0] m, input bit ok);
    @(negedge clock);
    push = 1; move_in = m;
    if (ok) exp_q.push_back(m);
    @(negedge clock);
    push = 0;
  endtask
  task automatic start();
    @(negedge clock);
    iniciar = 1;
    @(negedge clock);
    iniciar = 0;
  endtask
  task automatic wait_exec();
    int c = 0;
    while (executa !== 1'b1 && c < 200) begin
      @(negedge clock);
      c++;
    end
    if (c >= 200) begin
      tests++; fails++;
      $display("FAIL wait_exec timeout after %0d cycles", c);
    end
  endtask
  task automatic pulse_pronto();
    @(negedge clock);
    pronto_movimento = 1;
    @(negedge clock);
    pronto_movimento = 0;
  endtask
  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      wait_exec();
      repeat (3) @(negedge clock);
      pulse_pronto();
    end
    repeat (SETTLE + 4) @(negedge clock);
  endtask
  task automatic test_reset();
    reset = 1;
    #3;
    tests++;
    if ({move, executa, fim_sequencia, ocupado, vazio, cheio, contagem, db_estado} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0}) begin
      fails++;
      $display("FAIL reset_values move=%0d ex=%b fim=%b oc=%b vz=%b ch=%b cnt=%0d st=%0d required 0,0,0,0,1,0,0,0",
               move, executa, fim_sequencia, ocupado, vazio, cheio, contagem, db_estado);
    end
    repeat (2) @(negedge clock);
    reset = 0;
  endtask
  task automatic test_basic();
    int e0 = n_exec, f0 = n_fim;
    push_mv(3, 1); push_mv(1, 1); push_mv(4, 1);
    tests++;
    if (contagem !== 5'd3) begin fails++; $display("FAIL basic_count got=%0d required=3", contagem); end
    start();
    serve(3);
    tests++;
    if (n_exec - e0 !== 3) begin fails++; $display("FAIL basic_exec_count got=%0d required=3", n_exec - e0); end
    tests++;
    if (n_fim - f0 !== 1) begin fails++; $display("FAIL basic_fim_count got=%0d required=1", n_fim - f0); end
    tests++;
    if (vazio !== 1'b1 || db_estado !== 3'd0) begin fails++; $display("FAIL basic_end vazio=%b st=%0d required 1,0", vazio, db_estado); end
  endtask
  task automatic test_full();
    int e0 = n_exec;
    for (int i = 0; i < 16; i++) push_mv(3'(i % 8), 1);
    tests++;
    if (cheio !== 1'b1 || contagem !== 5'd16) begin fails++; $display("FAIL full_flag cheio=%b cnt=%0d required 1,16", cheio, contagem); end
    for (int i = 0; i < 5; i++) push_mv(3'(7 - i), 0);
    tests++;
    if (contagem !== 5'd16) begin fails++; $display("FAIL full_drop cnt=%0d required=16", contagem); end
    start();
    serve(16);
    tests++;
    if (n_exec - e0 !== 16 || vazio !== 1'b1) begin fails++; $display("FAIL full_drain execs=%0d vazio=%b required 16,1", n_exec - e0, vazio); end
  endtask
  task automatic test_empty();
    int e0 = n_exec;
    @(negedge clock);
    iniciar = 1;
    @(negedge clock);
    iniciar = 0;
    tests++;
    if (fim_sequencia !== 1'b1 || ocupado !== 1'b1 || db_estado !== 3'd5) begin
      fails++; $display("FAIL empty_fim fim=%b oc=%b st=%0d required 1,1,5", fim_sequencia, ocupado, db_estado);
    end
    @(negedge clock);
    tests++;
    if (fim_sequencia !== 1'b0 || ocupado !== 1'b0) begin fails++; $display("FAIL empty_after fim=%b oc=%b required 0,0", fim_sequencia, ocupado); end
    repeat (4) @(negedge clock);
    tests++;
    if (n_exec !== e0) begin fails++; $display("FAIL empty_noexec execs=%0d required=%0d", n_exec, e0); end
  endtask
  task automatic test_same_cycle();
    push_mv(7, 1); push_mv(2, 1);
    @(negedge clock);
    iniciar = 1;
    @(negedge clock);
    iniciar = 0;
    tests++;
    if (db_estado !== 3'd1 || contagem !== 5'd2) begin fails++; $display("FAIL same_carrega st=%0d cnt=%0d required 1,2", db_estado, contagem); end
    push = 1; move_in = 5; exp_q.push_back(3'd5);
    @(negedge clock);
    push = 0;
    tests++;
    if (contagem !== 5'd2 || move !== 3'd7) begin fails++; $display("FAIL same_cycle cnt=%0d move=%0d required 2,7", contagem, move); end
    serve(3);
  endtask
  task automatic test_cancel();
    int e0, f0;
    push_mv(6, 1); push_mv(1, 1); push_mv(2, 1); push_mv(3, 1);
    start();
    wait_exec();
    @(negedge clock);
    tests++;
    if (db_estado !== 3'd3 || contagem !== 5'd3) begin fails++; $display("FAIL cancel_pre st=%0d cnt=%0d required 3,3", db_estado, contagem); end
    e0 = n_exec; f0 = n_fim;
    cancela = 1; push = 1; move_in = 4;
    @(negedge clock);
    cancela = 0; push = 0;
    exp_q.delete();
    tests++;
    if (contagem !== 5'd0 || db_estado !== 3'd0 || vazio !== 1'b1) begin fails++; $display("FAIL cancel_flush cnt=%0d st=%0d vz=%b required 0,0,1", contagem, db_estado, vazio); end
    pulse_pronto();
    repeat (SETTLE + 4) @(negedge clock);
    tests++;
    if (db_estado !== 3'd0 || n_exec !== e0 || n_fim !== f0 || move !== 3'd6) begin
      fails++; $display("FAIL cancel_after st=%0d ex=%0d fim=%0d move=%0d required 0,%0d,%0d,6", db_estado, n_exec - e0, n_fim - f0, move, 0, 0);
    end
  endtask
  task automatic test_latency();
    int c;
    push_mv(2, 1); push_mv(5, 1);
    start();
    wait_exec();
    repeat (2) @(negedge clock);
    pronto_movimento = 1;
    c = 0;
    do begin @(negedge clock); pronto_movimento = 0; c++; end while (executa !== 1'b1 && c < 100);
    tests++;
    if (c !== LAT) begin fails++; $display("FAIL latency_exec got=%0d required=%0d", c, LAT); end
    repeat (2) @(negedge clock);
    pronto_movimento = 1;
    c = 0;
    do begin @(negedge clock); pronto_movimento = 0; c++; end while (fim_sequencia !== 1'b1 && c < 100);
    tests++;
    if (c !== LAT - 1) begin fails++; $display("FAIL latency_fim got=%0d required=%0d", c, LAT - 1); end
    repeat (3) @(negedge clock);
  endtask
  task automatic test_async_reset();
    push_mv(1, 0); push_mv(2, 0);
    @(negedge clock);
    iniciar = 1;
    @(posedge clock);
    #2 reset = 1;
    iniciar = 0;
    #1;
    tests++;
    if (contagem !== 5'd0 || db_estado !== 3'd0 || move !== 3'd0) begin fails++; $display("FAIL async_reset cnt=%0d st=%0d move=%0d required 0,0,0", contagem, db_estado, move); end
    @(negedge clock);
    reset = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_empty();
    test_same_cycle();
    test_cancel();
    test_latency();
    test_async_reset();
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
